// File: rtl/status_register_stack.sv
// Live condition-code register with a LIFO of saved snapshots for exception entry/return.
// Define STATUS_CC_BYPASS_EN to forward flags being written this cycle on cc_fwd.
module status_register_stack #(
    parameter int unsigned     CC_W      = 4,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [CC_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CC_W-1:0]            cc_in,
    input  logic                       S,
    input  logic                       push,
    input  logic                       pop,
    output logic [CC_W-1:0]            cc_out,
    output logic [CC_W-1:0]            cc_fwd,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CC_W-1:0] stack [DEPTH];
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [LW-1:0]   level_dec;

    // Indices are only used when level is in range (push: level<DEPTH, pop: level>0)
    assign level_dec = level - LW'(1);
    assign wr_idx    = level[IW-1:0];
    assign rd_idx    = level_dec[IW-1:0];

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cc_out  <= RESET_VAL;
            level   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (push && !pop) begin
            if (!full) begin
                stack[wr_idx] <= cc_out;
                level         <= level + LW'(1);
            end else begin
                ovf_err <= 1'b1;
            end
            if (S) begin
                cc_out <= cc_in;
            end
        end else if (pop && !push) begin
            // A successful restore takes precedence over the ALU update
            if (!empty) begin
                cc_out <= stack[rd_idx];
                level  <= level_dec;
            end else begin
                unf_err <= 1'b1;
                if (S) begin
                    cc_out <= cc_in;
                end
            end
        end else if (S) begin
            cc_out <= cc_in;
        end
    end

`ifdef STATUS_CC_BYPASS_EN
    always_comb begin
        cc_fwd = cc_out;
        if (S && !pop && !reset) begin
            cc_fwd = cc_in;
        end
    end
`else
    assign cc_fwd = cc_out;
`endif

endmodule

// File: tb/tb_status_register_stack.sv
// Table-driven scoreboard bench for status_register_stack (DEPTH=4) plus a DEPTH=1 corner sequence.
module tb_status_register_stack;

    localparam logic [3:0] RV = 4'h9;

    logic       clk = 1'b0;
    logic       reset, S, push, pop;
    logic [3:0] cc_in, cc_out, cc_fwd;
    logic [2:0] level;
    logic       full, empty, ovf_err, unf_err;

    logic       r1, s1, pu1, po1;
    logic [3:0] ci1, co1, cf1;
    logic [0:0] lv1;
    logic       fu1, em1, ov1, un1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    status_register_stack #(.CC_W(4), .DEPTH(4), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .cc_in(cc_in), .S(S), .push(push), .pop(pop),
        .cc_out(cc_out), .cc_fwd(cc_fwd), .level(level), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    status_register_stack #(.CC_W(4), .DEPTH(1), .RESET_VAL(4'h0)) dut1 (
        .clk(clk), .reset(r1), .cc_in(ci1), .S(s1), .push(pu1), .pop(po1),
        .cc_out(co1), .cc_fwd(cf1), .level(lv1), .full(fu1), .empty(em1),
        .ovf_err(ov1), .unf_err(un1)
    );

    typedef struct packed {
        logic       rst, s, pu, po;
        logic [3:0] ci;
        logic [3:0] e_cc;
        logic [2:0] e_lvl;
        logic       e_full, e_empty, e_ovf, e_unf;
    } vec_t;

    typedef struct packed {
        logic [3:0] cc;
        logic [2:0] lvl;
        logic       full, empty, ovf, unf;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t v(input logic rst, s, pu, po, input logic [3:0] ci,
                               input logic [3:0] ecc, input logic [2:0] elv,
                               input logic ef, ee, eo, eu);
        vec_t t;
        t = '{rst, s, pu, po, ci, ecc, elv, ef, ee, eo, eu};
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0] model_cc;
        logic [3:0] exp_fwd;
        exp_t       e, got;

        //                rst s pu po ci     cc    lvl  f  e  o  u
        tbl.push_back(v(1, 1, 1, 0, 4'hF, RV,   3'd0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 4'hA, 4'hA, 3'd0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 4'h3, 4'h3, 3'd0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'hC, 4'hC, 3'd1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 4'h0, 4'h3, 3'd0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 4'h1, 4'h1, 3'd0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h2, 4'h2, 3'd1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h3, 4'h3, 3'd2, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h4, 4'h4, 3'd3, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h5, 4'h5, 3'd4, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 4'h0, 4'h5, 3'd4, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 4'h0, 4'h4, 3'd3, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 4'h0, 4'h3, 3'd2, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 4'h0, 4'h2, 3'd1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 4'h0, 4'h1, 3'd0, 0, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 4'h0, 4'h1, 3'd0, 0, 1, 1, 1));
        tbl.push_back(v(0, 1, 0, 1, 4'h7, 4'h7, 3'd0, 0, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 4'h0, RV,   3'd0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 4'h1, 4'h1, 3'd0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h2, 4'h2, 3'd1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h3, 4'h3, 3'd2, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 1, 4'h6, 4'h6, 3'd2, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 4'hF, 4'h6, 3'd2, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 4'hF, 4'h2, 3'd1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 4'hF, 4'h1, 3'd0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h1, 4'h1, 3'd1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h2, 4'h2, 3'd2, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h3, 4'h3, 3'd3, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h4, 4'h4, 3'd4, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 4'h8, 4'h8, 3'd4, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 4'h0, 4'h3, 3'd3, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 1, 0, 4'h0, RV,   3'd0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 4'h0, RV,   3'd0, 0, 1, 0, 1));

        reset = 1'b1; S = 1'b0; push = 1'b0; pop = 1'b0; cc_in = '0;
        r1 = 1'b1; s1 = 1'b0; pu1 = 1'b0; po1 = 1'b0; ci1 = '0;
        @(posedge clk);
        #1;
        model_cc = RV;

        foreach (tbl[i]) begin
            @(negedge clk);
            reset = tbl[i].rst; S = tbl[i].s; push = tbl[i].pu;
            pop = tbl[i].po; cc_in = tbl[i].ci;
            #1;
`ifdef STATUS_CC_BYPASS_EN
            exp_fwd = (tbl[i].s && !tbl[i].po && !tbl[i].rst) ? tbl[i].ci : model_cc;
`else
            exp_fwd = model_cc;
`endif
            n_checks++;
            if (cc_out !== model_cc || cc_fwd !== exp_fwd) begin
                n_fail++;
                $display("FAIL pre%0d: cc_out=%h cc_fwd=%h, expected cc_out=%h cc_fwd=%h",
                         i, cc_out, cc_fwd, model_cc, exp_fwd);
            end
            sb.push_back('{tbl[i].e_cc, tbl[i].e_lvl, tbl[i].e_full, tbl[i].e_empty,
                           tbl[i].e_ovf, tbl[i].e_unf});
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = '{cc_out, level, full, empty, ovf_err, unf_err};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL vec%0d: got cc=%h lvl=%0d full=%b empty=%b ovf=%b unf=%b, expected cc=%h lvl=%0d full=%b empty=%b ovf=%b unf=%b",
                         i, got.cc, got.lvl, got.full, got.empty, got.ovf, got.unf,
                         e.cc, e.lvl, e.full, e.empty, e.ovf, e.unf);
            end
            model_cc = e.cc;
        end

        @(negedge clk);
        reset = 1'b0; S = 1'b0; push = 1'b0; pop = 1'b0;

        // DEPTH=1: single slot fills on first push, overflows on second
        step1(1, 0, 0, 0, 4'h0, 4'h0, 1'b0, 0, 1, 0, 0);
        step1(0, 1, 0, 0, 4'h5, 4'h5, 1'b0, 0, 1, 0, 0);
        step1(0, 1, 1, 0, 4'hA, 4'hA, 1'b1, 1, 0, 0, 0);
        step1(0, 1, 1, 0, 4'hB, 4'hB, 1'b1, 1, 0, 1, 0);
        step1(0, 1, 0, 1, 4'hF, 4'h5, 1'b0, 0, 1, 1, 0);
        step1(0, 0, 0, 1, 4'h0, 4'h5, 1'b0, 0, 1, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    task automatic step1(input logic rst, s, pu, po, input logic [3:0] ci,
                         input logic [3:0] ecc, input logic [0:0] elv,
                         input logic ef, ee, eo, eu);
        @(negedge clk);
        r1 = rst; s1 = s; pu1 = pu; po1 = po; ci1 = ci;
        @(posedge clk);
        #1;
        n_checks++;
        if (co1 !== ecc || lv1 !== elv || fu1 !== ef || em1 !== ee || ov1 !== eo || un1 !== eu) begin
            n_fail++;
            $display("FAIL d1: got cc=%h lvl=%0d full=%b empty=%b ovf=%b unf=%b, expected cc=%h lvl=%0d full=%b empty=%b ovf=%b unf=%b",
                     co1, lv1, fu1, em1, ov1, un1, ecc, elv, ef, ee, eo, eu);
        end
    endtask

endmodule

// File: doc/status_register_stack.md
Name: status_register_stack

Overview:
- Parametrised successor to the single 4-bit condition-code status register used by the pipelined control unit.
- Holds the live condition-code (CC) flags. Updates them from the execute stage when the S bit is set.
- Adds a save/restore stack of CC snapshots for exception entry and return, with full/empty/error reporting.
- Optionally provides a same-cycle bypass path so the decode-stage condition tester sees flags written this cycle.

Parameters:
- CC_W, 4, width of the condition-code vector (N,Z,C,V at the default width; MSB = N).
- DEPTH, 4, number of saved snapshots the stack holds; legal range 1..16.
- RESET_VAL, 0, value loaded into cc_out on reset (CC_W bits).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cc_in  input  CC_W  new flags from the ALU.
- S  input  1  flag-update enable; when 1, cc_in is written to cc_out.
- push  input  1  exception entry: save the current cc_out onto the stack.
- pop  input  1  exception return: restore cc_out from the top of the stack.
- cc_out  output  CC_W  registered live flags.
- cc_fwd  output  CC_W  forwarded flags (see Optional Feature).
- level  output  $clog2(DEPTH+1)  number of valid stack entries.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- ovf_err  output  1  sticky: a push occurred while full.
- unf_err  output  1  sticky: a pop occurred while empty.

Behaviour:
- Reset, sampled at a rising clk edge with reset=1:
  - cc_out=RESET_VAL, level=0, empty=1, full=0, ovf_err=0, unf_err=0.
  - Stack contents are don't-care.
  - Reset overrides push, pop and S in the same cycle.
  - Reset asserted mid-sequence discards all saved snapshots.
- full and empty are combinational decodes of level. There is no other combinational path to them.
- Per-edge priority, evaluated after reset:
  - push=1, pop=1: the stack is unchanged and level holds. S applies normally: cc_out=cc_in if S, else it holds. No error flags change.
  - push=1 only, not full:
    - stack[level] <= cc_out (the pre-update value); level+1.
    - If S=1, cc_out <= cc_in in the same edge.
  - push=1 only, full:
    - The push is dropped; stack and level are unchanged; ovf_err <= 1.
    - S still updates cc_out.
  - pop=1 only, not empty:
    - cc_out <= stack[level-1]; level-1.
    - S is ignored this cycle (restore wins over ALU update).
  - pop=1 only, empty:
    - level and cc_out are unchanged; unf_err <= 1.
    - S still updates cc_out.
  - Neither push nor pop: cc_out <= cc_in if S=1, else it holds.
- Latency: one cycle from S, push or pop to a visible change on cc_out and level.
- Stack order is LIFO. The maximum nesting is DEPTH; level never exceeds DEPTH and never goes below 0.
- Error flags are sticky; only reset clears them.

Optional Feature:
- Macro: STATUS_CC_BYPASS_EN.
- When defined:
  - cc_fwd is combinational: cc_in when S=1 and pop=0 and reset=0, else cc_out.
  - This lets the condition tester in the same cycle see flags being written.
- When undefined: cc_fwd = cc_out (registered only, one-cycle lag).

Test Plan:
- Reset then S=1, cc_in=4'b1010 for one edge -> cc_out=4'b1010 after the edge; level=0; empty=1; cc_out=RESET_VAL before that edge.
- cc_out=4'b0011, then push with S=1 and cc_in=4'b1100 -> stack top=4'b0011, cc_out=4'b1100, level=1. A following pop -> cc_out=4'b0011, level=0, empty=1.
- DEPTH=4: push 5 times with distinct cc_out values 1..5 -> level=4, full=1, ovf_err=1. Then pop 4 times -> cc_out returns 4,3,2,1 in order; a 5th pop -> unf_err=1, cc_out holds 1.
- push=1 and pop=1 together with level=2, S=1, cc_in=4'b0110 -> level stays 2, cc_out=4'b0110, no error flags set.
- pop with S=1, cc_in=4'b1111, stack top 4'b0001 -> cc_out=4'b0001. With STATUS_CC_BYPASS_EN defined, cc_fwd=cc_out during the pop; with S=1 and no pop, cc_fwd=cc_in in the same cycle.
- Assert reset at level=3 with ovf_err=1 -> next edge: level=0, ovf_err=0, cc_out=RESET_VAL.
